// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, queue entry layout and
// the JAL target helper used when FETCH_JAL_PREDICT_EN is defined.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [6:0] JAL_OPCODE = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } queue_entry_t;

    // Reassembles the scrambled J-type immediate from instruction bits [31:12].
    function automatic logic [31:0] jal_offset(input logic [31:12] i_imm_bits);
        return {{12{i_imm_bits[31]}}, i_imm_bits[19:12], i_imm_bits[20],
                i_imm_bits[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with flush; DEPTH must be a power of two
// so the head/tail pointers wrap by natural overflow.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  queue_entry_t                 i_data,
    input  logic                         i_pop,
    output queue_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    queue_entry_t     r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_head];

    // Flush wins over both operations; a push at full is allowed only alongside a pop.
    assign w_do_pop  = i_pop  && !i_flush && !o_empty;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + 1'b1;
            if (w_do_pop)  r_head <= r_head + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_tail] <= i_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a decode queue.
// Optional macro FETCH_JAL_PREDICT_EN redirects the fetch PC to JAL targets on push.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic                               memReq,
    output logic [31:0]                        memAddr,
    input  logic                               memReady,
    input  logic [31:0]                        memData,
    input  logic                               decodeReady,
    output logic                               decodePulse,
    output logic [31:0]                        instr,
    output logic [31:0]                        pcNumber,
    input  logic                               redirectValid,
    input  logic [31:0]                        redirectPC,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queueCount
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         r_memReq;
    logic         w_memReq_next;
    logic [31:0]  r_memAddr;
    logic [31:0]  w_memAddr_next;
    logic         r_decodePulse;
    logic [31:0]  r_instr;
    logic [31:0]  r_pcNumber;

    logic         w_push;
    logic         w_pop;
    logic         w_empty;
    logic         w_full;
    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_seq_pc;
    queue_entry_t w_push_entry;
    queue_entry_t w_head;

    assign w_redirect_pc = redirectPC & ~32'd3;
    assign w_push_entry  = '{pc: r_pc, instr: memData};
    assign w_pop         = !redirectValid && decodeReady && !w_empty;

`ifdef FETCH_JAL_PREDICT_EN
    assign w_seq_pc = (memData[6:0] == JAL_OPCODE) ? r_pc + jal_offset(memData[31:12])
                                                   : r_pc + 32'd4;
`else
    assign w_seq_pc = r_pc + 32'd4;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_memReq_next  = r_memReq;
        w_memAddr_next = r_memAddr;
        w_push         = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirectValid) begin
                    w_pc_next = w_redirect_pc;
                end else if (!w_full) begin
                    w_memReq_next  = 1'b1;
                    w_memAddr_next = r_pc;
                    w_state_next   = WAIT;
                end
            end
            WAIT: begin
                if (redirectValid) begin
                    w_pc_next = w_redirect_pc;
                    if (memReady) begin
                        w_memReq_next = 1'b0;
                        w_state_next  = IDLE;
                    end else begin
                        w_state_next  = DROP;
                    end
                end else if (memReady) begin
                    w_push        = 1'b1;
                    w_pc_next     = w_seq_pc;
                    w_memReq_next = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            DROP: begin
                if (redirectValid) w_pc_next = w_redirect_pc;
                // A redirect coinciding with the stale completion still retires it;
                // remaining in DROP would wait on a response that never comes.
                if (memReady) begin
                    w_memReq_next = 1'b0;
                    w_state_next  = IDLE;
                end
            end
            default: begin
                w_memReq_next = 1'b0;
                w_state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_memReq      <= 1'b0;
            r_memAddr     <= '0;
            r_decodePulse <= 1'b0;
            r_instr       <= '0;
            r_pcNumber    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_memReq      <= w_memReq_next;
            r_memAddr     <= w_memAddr_next;
            r_decodePulse <= w_pop;
            if (w_pop) begin
                r_instr    <= w_head.instr;
                r_pcNumber <= w_head.pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_flush (redirectValid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (queueCount),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign memReq      = r_memReq;
    assign memAddr     = r_memAddr;
    assign decodePulse = r_decodePulse;
    assign instr       = r_instr;
    assign pcNumber    = r_pcNumber;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed cycle-by-cycle bench for instruction_fetch (default QUEUE_DEPTH=4, RESET_PC=0).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady = 1'b0;
    logic [31:0] memData = '0;
    logic        decodeReady = 1'b0;
    logic        decodePulse;
    logic [31:0] instr;
    logic [31:0] pcNumber;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPC = '0;
    logic [2:0]  queueCount;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cyc    = 0;
    logic [31:0] exp_jal_next;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0100_006F;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    instruction_fetch #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memReady      (memReady),
        .memData       (memData),
        .decodeReady   (decodeReady),
        .decodePulse   (decodePulse),
        .instr         (instr),
        .pcNumber      (pcNumber),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .queueCount    (queueCount)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive inputs for the next edge, then check registered outputs 1ns after it.
    task automatic cyc(input logic mr, input logic [31:0] md, input logic dr,
                       input logic rv, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_pulse,
                       input logic [31:0] e_pcn, input logic [31:0] e_cnt);
        memReady = mr; memData = md; decodeReady = dr; redirectValid = rv; redirectPC = rpc;
        @(posedge clock);
        #1;
        n_cyc++;
        check_eq($sformatf("c%0d memReq", n_cyc), {31'b0, memReq}, {31'b0, e_req});
        if (e_req) check_eq($sformatf("c%0d memAddr", n_cyc), memAddr, e_addr);
        check_eq($sformatf("c%0d decodePulse", n_cyc), {31'b0, decodePulse}, {31'b0, e_pulse});
        check_eq($sformatf("c%0d pcNumber", n_cyc), pcNumber, e_pcn);
        check_eq($sformatf("c%0d queueCount", n_cyc), {29'b0, queueCount}, e_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " memReq"}, {31'b0, memReq}, 32'd0);
        check_eq({tag, " memAddr"}, memAddr, 32'd0);
        check_eq({tag, " decodePulse"}, {31'b0, decodePulse}, 32'd0);
        check_eq({tag, " instr"}, instr, 32'd0);
        check_eq({tag, " pcNumber"}, pcNumber, 32'd0);
        check_eq({tag, " queueCount"}, {29'b0, queueCount}, 32'd0);
    endtask

    initial begin
`ifdef FETCH_JAL_PREDICT_EN
        exp_jal_next = 32'h0000_2010;
`else
        exp_jal_next = 32'h0000_2004;
`endif
        #1 reset = 1'b1;
        #2 check_reset_outputs("por");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Straight-line fetch with decode always ready
        //  mr  data  dr  rv  rpc           req addr          pul pcNumber      cnt
        cyc(0, '0,   1, 0, '0,            1, 32'h0,         0, 32'h0,         0);
        cyc(1, NOP,  1, 0, '0,            0, '0,            0, 32'h0,         1);
        cyc(0, '0,   1, 0, '0,            1, 32'h4,         1, 32'h0,         0);
        check_eq("first instr", instr, NOP);
        cyc(1, NOP,  1, 0, '0,            0, '0,            0, 32'h0,         1);
        cyc(0, '0,   1, 0, '0,            1, 32'h8,         1, 32'h4,         0);
        cyc(1, NOP,  1, 0, '0,            0, '0,            0, 32'h4,         1);
        cyc(0, '0,   1, 0, '0,            1, 32'hC,         1, 32'h8,         0);

        // Decode stalled, memory always ready: fill to 4 then stop requesting
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h8,         1);
        cyc(1, NOP,  0, 0, '0,            1, 32'h10,        0, 32'h8,         1);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h8,         2);
        cyc(1, NOP,  0, 0, '0,            1, 32'h14,        0, 32'h8,         2);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h8,         3);
        cyc(1, NOP,  0, 0, '0,            1, 32'h18,        0, 32'h8,         3);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h8,         4);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h8,         4);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h8,         4);
        // One pop at full re-enables exactly one request; request holds while waiting
        cyc(0, '0,   1, 0, '0,            0, '0,            1, 32'hC,         3);
        cyc(0, '0,   0, 0, '0,            1, 32'h1C,        0, 32'hC,         3);
        cyc(0, '0,   0, 0, '0,            1, 32'h1C,        0, 32'hC,         3);

        // Redirect while waiting: stale response dropped, refetch from aligned target
        cyc(0, '0,   0, 1, 32'h0000_1002, 1, 32'h1C,        0, 32'hC,         0);
        cyc(0, '0,   0, 0, '0,            1, 32'h1C,        0, 32'hC,         0);
        cyc(1, JUNK, 0, 0, '0,            0, '0,            0, 32'hC,         0);
        cyc(0, '0,   0, 0, '0,            1, 32'h0000_1000, 0, 32'hC,         0);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'hC,         1);
        cyc(0, '0,   0, 0, '0,            1, 32'h0000_1004, 0, 32'hC,         1);

        // Redirect coincident with memReady and decodeReady
        cyc(1, NOP,  1, 1, 32'h0000_2000, 0, '0,            0, 32'hC,         0);
        cyc(0, '0,   1, 0, '0,            1, 32'h0000_2000, 0, 32'hC,         0);

        // JAL word: plain +4 unless prediction is compiled in
        cyc(1, JAL,  0, 0, '0,            0, '0,            0, 32'hC,         1);
        cyc(0, '0,   1, 0, '0,            1, exp_jal_next,  1, 32'h0000_2000, 0);
        check_eq("jal instr", instr, JAL);

        // PC wrap at the top of the address space (unaligned target gets aligned)
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h0000_2000, 1);
        cyc(0, '0,   0, 1, 32'hFFFF_FFFF, 0, '0,            0, 32'h0000_2000, 0);
        cyc(0, '0,   0, 0, '0,            1, 32'hFFFF_FFFC, 0, 32'h0000_2000, 0);
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h0000_2000, 1);
        cyc(0, '0,   1, 0, '0,            1, 32'h0,         1, 32'hFFFF_FFFC, 0);

        // Asynchronous reset mid-WAIT, with memReady around and after it ignored
        #2;
        memReady = 1'b1;
        memData  = JUNK;
        reset    = 1'b1;
        #1 check_reset_outputs("async");
        @(posedge clock);
        #1 reset = 1'b0;
        cyc(1, JUNK, 0, 0, '0,            1, 32'h0,         0, 32'h0,         0);

        // Simultaneous push and pop keep the count; back-to-back decode pulses
        cyc(1, NOP,  0, 0, '0,            0, '0,            0, 32'h0,         1);
        cyc(0, '0,   0, 0, '0,            1, 32'h4,         0, 32'h0,         1);
        cyc(1, NOP,  1, 0, '0,            0, '0,            1, 32'h0,         1);
        cyc(0, '0,   1, 0, '0,            1, 32'h8,         1, 32'h4,         0);
        cyc(0, '0,   1, 0, '0,            1, 32'h8,         0, 32'h4,         0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: QUEUE_DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-003 Port: clock  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: memReq  out  1  instruction memory read request.
REQ-006 Port: memAddr  out  32  word-aligned read address.
REQ-007 Port: memReady  in  1  one-cycle strobe; memData valid this cycle.
REQ-008 Port: memData  in  32  fetched instruction word.
REQ-009 Port: decodeReady  in  1  downstream decode/issue can accept an instruction.
REQ-010 Port: decodePulse  out  1  one-cycle strobe; instr/pcNumber valid.
REQ-011 Port: instr  out  32  instruction word to decode.
REQ-012 Port: pcNumber  out  32  PC of instr.
REQ-013 Port: redirectValid  in  1  one-cycle flush/redirect request from branch resolution.
REQ-014 Port: redirectPC  in  32  redirect target.
REQ-015 Port: queueCount  out  $clog2(QUEUE_DEPTH+1)  occupied queue entries.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DROP.
REQ-017 IDLE, no redirect, queueCount < QUEUE_DEPTH: next cycle memReq=1, memAddr=pc, go WAIT.
REQ-018 WAIT: memReq and memAddr SHALL hold stable until the memReady cycle.
REQ-019 WAIT with memReady: push {pc, memData} to queue tail, pc <= pc+4 (mod 2^32), memReq=0, go IDLE; minimum request spacing is 2 cycles.
REQ-020 Issue: queue non-empty and decodeReady, no redirect -> next cycle decodePulse=1 for exactly one cycle with head instr/pcNumber, head popped.
REQ-021 instr and pcNumber SHALL be registered and hold their last values while decodePulse=0.
REQ-022 Push and pop in the same cycle SHALL leave queueCount unchanged; head/tail pointers wrap modulo QUEUE_DEPTH.
REQ-023 A new request SHALL NOT start when queueCount == QUEUE_DEPTH; a pop at full re-enables it the following cycle.
REQ-024 redirectValid has top priority: queue flushed (queueCount=0), pc <= {redirectPC[31:2],2'b00}, no decodePulse the next cycle.
REQ-025 Redirect in IDLE -> IDLE; in WAIT without memReady -> DROP; in WAIT with memReady -> data discarded, IDLE.
REQ-026 DROP: memReq/memAddr held on the stale request until memReady; data discarded; then IDLE using the redirected pc.
REQ-027 Redirect during DROP SHALL update pc and remain in DROP.

Reset
REQ-028 Reset assertion SHALL immediately force memReq=0, memAddr=0, decodePulse=0, instr=0, pcNumber=0, queueCount=0, pc=RESET_PC, state IDLE.
REQ-029 Reset mid-WAIT/DROP SHALL abandon the transaction; a memReady arriving during or after reset while in IDLE SHALL be ignored.

Configuration
REQ-030 Macro FETCH_JAL_PREDICT_EN: when defined, a word pushed with opcode 7'b1101111 (JAL) SHALL set pc <= pushed PC + sign-extended {imm[20:1],1'b0} instead of pc+4; no queue flush.
REQ-031 Without FETCH_JAL_PREDICT_EN, pc SHALL always advance by 4 except on redirectValid.

Structure
REQ-032 Package fetch_pkg SHALL hold the FSM state enum, the JAL opcode constant and a queue-entry typedef {pc[31:0], instr[31:0]}.
REQ-033 Queue SHALL be a sub-module fetch_queue (synchronous FIFO with flush, push, pop, count); FSM and PC logic stay in instruction_fetch.

Verification
REQ-034 Reset, decodeReady=1, memReady 1 cycle after each memReq, memData=32'h0000_0013 -> memAddr 0,4,8; decodePulse per word, pcNumber 0,4,8.
REQ-035 decodeReady=0, memory always ready -> exactly 4 pushes, queueCount=4, memReq stays 0; decodeReady=1 one cycle -> one pop, one new request.
REQ-036 Redirect to 32'h0000_1002 while in WAIT -> DROP, stale data discarded, next memAddr=32'h0000_1000, queueCount=0.
REQ-037 Redirect in the same cycle as memReady and decodeReady -> no push, no decodePulse next cycle, pc=redirect target.
REQ-038 pc=32'hFFFF_FFFC fetch -> next memAddr 32'h0000_0000; with FETCH_JAL_PREDICT_EN, JAL imm=+16 at pc 8 -> next memAddr 24.
